// File: rtl/anim_pkg.sv
// Shared definitions for the sprite animation sequencer.
//   anim_state_t : sequencer FSM states
//   OP_DRAW/ERASE: request opcode sent to the draw engine
//   SCREEN_W/H   : visible VGA area the origins must stay inside
//   anim_req_t   : registered request fields held stable while req_valid is high
//   next_x       : x-origin advance with wrap back to the start column
package anim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAW_REQ,
        DRAW_WAIT,
        HOLD,
        ERASE_REQ,
        ERASE_WAIT,
        ADVANCE
    } anim_state_t;

    localparam logic OP_DRAW  = 1'b0;
    localparam logic OP_ERASE = 1'b1;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    typedef struct packed {
        logic       op;
        logic [1:0] pose;
        logic [8:0] x;
        logic [7:0] y;
    } anim_req_t;

    // Sum is formed at 10 bits so x + step cannot wrap before the limit test.
    function automatic logic [8:0] next_x(input logic [8:0] x, input int step,
                                          input int start, input int limit);
        logic [9:0] sum;
        sum = {1'b0, x} + 10'(step);
        return (sum > 10'(limit)) ? 9'(start) : sum[8:0];
    endfunction

endpackage

// File: rtl/anim_sequencer_if.sv
// Request/done channel between the animation sequencer and the draw engine.
//   req_valid/req_ready : one-at-a-time request handshake
//   req_op/pose/x/y     : request fields, stable while req_valid is high
//   done                : engine pulse, one cycle, after finishing a request
// master = sequencer side, slave = draw-engine side.
interface anim_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [1:0] req_pose;
    logic [8:0] req_x;
    logic [7:0] req_y;
    logic       done;

    modport master (
        output req_valid, req_op, req_pose, req_x, req_y,
        input  req_ready, done
    );

    modport slave (
        input  req_valid, req_op, req_pose, req_x, req_y,
        output req_ready, done
    );
endinterface

// File: rtl/anim_sequencer_key_edge_sync.sv
// Synchroniser and press detector for an active-low push button.
//   clk, reset : system clock, synchronous active-low reset
//   key_n      : raw button, asynchronous, low while pressed
//   pulse      : one-cycle high on each press (falling edge of key_n)
// Flops reset to 1 (released) so a reset never fakes a press.
module key_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);
    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s3 & ~s2;
endmodule

// File: rtl/anim_sequencer.sv
// Animation sequencer: turns a KEY press into a looping draw/hold/erase/advance
// sequence issued to the sprite draw engine, one request at a time.
//   clk, reset : system clock, synchronous active-low reset
//   start_n    : raw KEY (active low, async); a press starts the animation
//   stop       : one-cycle request to stop after the current frame
//   req        : master side of anim_sequencer_if (request + done)
//   busy       : high in every state except IDLE
//   frame_cnt  : completed frames, wrapping 255 -> 0
module anim_sequencer
    import anim_pkg::*;
#(
    parameter int HOLD_CYCLES = 25000000,
    parameter int NUM_POSES   = 4,
    parameter int X_START     = 90,
    parameter int X_STEP      = 16,
    parameter int X_LIMIT     = 220,
    parameter int Y_ORIGIN    = 70
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_n,
    input  logic                    stop,
    anim_sequencer_if.master        req,
    output logic                    busy,
    output logic [7:0]              frame_cnt
);
    localparam int              TW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0]   HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [1:0]      POSE_LAST = 2'(NUM_POSES - 1);

    anim_state_t   state, state_d;
    logic [TW-1:0] timer;
    logic          stop_pending;
    anim_req_t     rq;
    logic [7:0]    frame_q;
    logic          start_pulse;

    key_edge_sync u_start_sync (
        .clk   (clk),
        .reset (reset),
        .key_n (start_n),
        .pulse (start_pulse)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // done is only looked at in the *_WAIT states, so a done coincident with
    // the handshake edge (still in *_REQ) is dropped on purpose.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:       if (start_pulse)   state_d = DRAW_REQ;
            DRAW_REQ:   if (req.req_ready) state_d = DRAW_WAIT;
            DRAW_WAIT:  if (req.done)      state_d = HOLD;
            HOLD:       if (timer == HOLD_LAST) state_d = ERASE_REQ;
            ERASE_REQ:  if (req.req_ready) state_d = ERASE_WAIT;
            ERASE_WAIT: if (req.done)      state_d = ADVANCE;
            ADVANCE:    state_d = stop_pending ? IDLE : DRAW_REQ;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer        <= '0;
            stop_pending <= 1'b0;
            rq           <= '{op: OP_DRAW, pose: 2'd0, x: 9'(X_START), y: 8'(Y_ORIGIN)};
            frame_q      <= 8'd0;
        end else begin
            // Timer sits at zero outside HOLD, so entering HOLD starts it at 0.
            if (state == HOLD) timer <= timer + TW'(1);
            else               timer <= '0;

            if (state == ADVANCE && stop_pending)
                stop_pending <= 1'b0;
            else if (stop && state != IDLE)
                stop_pending <= 1'b1;

            // Opcode is set on the way into a request state, so it is already
            // stable on the first cycle req_valid is high.
            if (state_d == ERASE_REQ)     rq.op <= OP_ERASE;
            else if (state_d == DRAW_REQ) rq.op <= OP_DRAW;

            if (state == IDLE && start_pulse) begin
                rq.pose <= 2'd0;
                rq.x    <= 9'(X_START);
            end

            if (state == ADVANCE) begin
                rq.pose <= (rq.pose == POSE_LAST) ? 2'd0 : rq.pose + 2'd1;
                rq.x    <= next_x(rq.x, X_STEP, X_START, X_LIMIT);
                frame_q <= frame_q + 8'd1;
            end
        end
    end

    assign req.req_valid = (state == DRAW_REQ) || (state == ERASE_REQ);
    assign req.req_op    = rq.op;
    assign req.req_pose  = rq.pose;
    assign req.req_x     = rq.x;
    assign req.req_y     = rq.y;
    assign busy          = (state != IDLE);
    assign frame_cnt     = frame_q;
endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer with HOLD_CYCLES = 8.
// Stimulus pushes each expected request {op,pose,x,y}; a negedge monitor pops
// and compares on every valid&ready transfer.
module tb_anim_sequencer;
    logic       clk = 1'b0;
    logic       reset, start_n, stop, busy;
    logic [7:0] frame_cnt;
    int         checks = 0;
    int         errors = 0;
    logic [19:0] exp_q[$];

    anim_sequencer_if bus ();

    anim_sequencer #(
        .HOLD_CYCLES(8), .NUM_POSES(4), .X_START(90),
        .X_STEP(16), .X_LIMIT(220), .Y_ORIGIN(70)
    ) dut (
        .clk(clk), .reset(reset), .start_n(start_n), .stop(stop),
        .req(bus), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.req_valid && bus.req_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got %0h want none",
                         {bus.req_op, bus.req_pose, bus.req_x, bus.req_y});
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                chk("req_fields", 32'({bus.req_op, bus.req_pose, bus.req_x, bus.req_y}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input bit early_done);
        for (int i = 0; i < 50 && !bus.req_valid; i++) tick();
        if (!bus.req_valid) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got no req_valid want req_valid within 50 cycles");
        end
        bus.req_ready = 1'b1;
        bus.done      = early_done;
        tick();
        bus.req_ready = 1'b0;
        bus.done      = 1'b0;
        chk("valid_drop", 32'(bus.req_valid), 32'd0);
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    task automatic draw_half(input logic [1:0] pose, input logic [8:0] x,
                             input bit early_done, input bit stop_hold);
        int n;
        exp_q.push_back({1'b0, pose, x, 8'd70});
        handshake(early_done);
        tick();
        tick();
        pulse_done();
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            if (stop_hold && i == 3) stop = 1'b1;
            tick();
            stop = 1'b0;
            if (bus.req_valid) begin
                n = i;
                break;
            end
        end
        chk("hold_len", 32'(n), 32'd8);
        chk("erase_op", 32'(bus.req_op), 32'd1);
    endtask

    task automatic erase_half(input logic [1:0] pose, input logic [8:0] x);
        exp_q.push_back({1'b1, pose, x, 8'd70});
        handshake(1'b0);
        tick();
        tick();
        pulse_done();
    endtask

    task automatic do_start(input bit stop_at_pulse);
        start_n = 1'b0;
        tick();
        tick();
        chk("busy_before_draw", 32'(busy), 32'd0);
        if (stop_at_pulse) stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("start_latency", 32'(bus.req_valid), 32'd1);
        chk("busy_running", 32'(busy), 32'd1);
        start_n = 1'b1;
    endtask

    logic [1:0] pose_tbl [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
                                  2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [8:0] x_tbl [12]    = '{9'd90, 9'd106, 9'd122, 9'd138, 9'd154, 9'd170,
                                  9'd186, 9'd202, 9'd218, 9'd90, 9'd106, 9'd122};

    initial begin
        reset = 1'b0; start_n = 1'b1; stop = 1'b0;
        bus.req_ready = 1'b0; bus.done = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 32'(bus.req_valid), 32'd0);
        chk("rst_op",    32'(bus.req_op),    32'd0);
        chk("rst_pose",  32'(bus.req_pose),  32'd0);
        chk("rst_x",     32'(bus.req_x),     32'd90);
        chk("rst_y",     32'(bus.req_y),     32'd70);
        chk("rst_frame", 32'(frame_cnt),     32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        reset = 1'b1;
        repeat (6) tick();

        do_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_fields",
                32'({bus.req_valid, bus.req_op, bus.req_pose, bus.req_x, bus.req_y}),
                32'({1'b1, 1'b0, 2'd0, 9'd90, 8'd70}));
        end

        // Frame 1 raises done together with its draw handshake (must be ignored);
        // frame 11 pulses stop during HOLD.
        for (int f = 0; f < 12; f++) begin
            draw_half(pose_tbl[f], x_tbl[f], f == 1, f == 11);
            erase_half(pose_tbl[f], x_tbl[f]);
            tick();
            if (f == 3) chk("frame_cnt_4", 32'(frame_cnt), 32'd4);
        end
        chk("stop_busy",  32'(busy),      32'd0);
        chk("stop_frame", 32'(frame_cnt), 32'd12);
        repeat (5) tick();
        chk("idle_no_req", 32'(bus.req_valid), 32'd0);

        // stop in IDLE, and stop coinciding with the start pulse: both ignored.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_start(1'b1);
        draw_half(2'd0, 9'd90, 1'b0, 1'b0);
        erase_half(2'd0, 9'd90);
        tick();
        chk("restart_frame", 32'(frame_cnt), 32'd13);
        chk("restart_continues", 32'(busy), 32'd1);

        // Reset while waiting for the erase done.
        draw_half(2'd1, 9'd106, 1'b0, 1'b0);
        exp_q.push_back({1'b1, 2'd1, 9'd106, 8'd70});
        handshake(1'b0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("midrst_valid", 32'(bus.req_valid), 32'd0);
        chk("midrst_x",     32'(bus.req_x),     32'd90);
        chk("midrst_pose",  32'(bus.req_pose),  32'd0);
        chk("midrst_frame", 32'(frame_cnt),     32'd0);
        chk("midrst_busy",  32'(busy),          32'd0);
        reset = 1'b1;
        tick();
        pulse_done();
        repeat (10) tick();
        chk("late_done_valid", 32'(bus.req_valid), 32'd0);
        chk("late_done_busy",  32'(busy),          32'd0);
        chk("sb_drained",      32'(exp_q.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
